dac_wave_ctrl: RTL and testbench



---
 rtl/dac_wave_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dac_wave_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_wave_ctrl.sv
// -----------------------------------------------------------------------------
// dac_wave_ctrl
//
// Plays a waveform stored in an internal sample buffer out to a parallel DAC.
// Each sample period is div+1 clocks long:
//   SETUP  (data valid, strobes idle)
//   STROBE (dac_we_n low)
//   LATCH  (dac_ldac_n low)
//   WAIT   (fills the rest of the period, at least one cycle)
// The buffer can be rewritten at any time. A write to the next sample to be
// played shows up in the following period.
//
// Ports
//   new_clk      sole clock, rising edge
//   reset        synchronous, active-high
//   cfg_we       write cfg_data into buffer[cfg_addr]
//   cfg_addr     buffer write address
//   cfg_data     buffer write data
//   cfg_len      index of last sample to play (captured on accepted start)
//   cfg_div      clocks per sample minus 1, clamped to >= 3 (captured on start)
//   cfg_oneshot  1 = play once, 0 = loop (captured on start)
//   start        single-cycle playback request (ignored while busy)
//   stop         single-cycle abort request (ignored while idle)
//   to_daq       DAC parallel data
//   dac_we_n     DAC write strobe, active-low
//   dac_ldac_n   DAC load strobe, active-low
//   dac_rst_n    DAC reset, active-low, held one cycle past reset
//   busy         high whenever the controller is not idle
//   sample_idx   index of the sample currently on to_daq
//   wrap         one-cycle pulse in the LATCH cycle of the last sample
//   done         one-cycle pulse when one-shot playback completes
// -----------------------------------------------------------------------------
module dac_wave_ctrl #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] MIDSCALE = 16'h8000
) (
  input  logic              new_clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [15:0]       cfg_div,
  input  logic              cfg_oneshot,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] to_daq,
  output logic              dac_we_n,
  output logic              dac_ldac_n,
  output logic              dac_rst_n,
  output logic              busy,
  output logic [ADDR_W-1:0] sample_idx,
  output logic              wrap,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    SETUP,
    STROBE,
    LATCH,
    WAIT
  } state_t;

  localparam logic [15:0]       DIV_MIN = 16'd3;
  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] idx;        // index of the next sample to load
  logic [ADDR_W-1:0] len_q;
  logic [15:0]       div_q;
  logic              oneshot_q;
  logic [15:0]       wait_cnt;
  logic              stop_pend;  // stop seen in SETUP/STROBE, honoured after LATCH
  logic              rst_hold;

  // ---------------------------------------------------------------------------
  // Sample buffer
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] buffer [2**ADDR_W];

  // NOTE: the buffer is deliberately left out of reset so stored waveforms
  // survive a controller reset and the array can map onto RAM.
  always_ff @(posedge new_clk) begin
    if (cfg_we) buffer[cfg_addr] <= cfg_data;
  end

  // ---------------------------------------------------------------------------
  // DAC reset: held low during reset and for one further cycle afterwards.
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge new_clk) begin
    if (reset) begin
      rst_hold  <= 1'b1;
      dac_rst_n <= 1'b0;
    end else begin
      rst_hold  <= 1'b0;
      dac_rst_n <= ~rst_hold;
    end
  end

  // ---------------------------------------------------------------------------
  // Playback FSM. Outputs are registered and set on the edge entering the
  // state they belong to.
  // ---------------------------------------------------------------------------
  always_ff @(posedge new_clk) begin
    if (reset) begin
      state      <= IDLE;
      to_daq     <= MIDSCALE;
      dac_we_n   <= 1'b1;
      dac_ldac_n <= 1'b1;
      busy       <= 1'b0;
      sample_idx <= '0;
      wrap       <= 1'b0;
      done       <= 1'b0;
      idx        <= '0;
      len_q      <= '0;
      div_q      <= DIV_MIN;
      oneshot_q  <= 1'b0;
      wait_cnt   <= '0;
      stop_pend  <= 1'b0;
    end else begin
      dac_we_n   <= 1'b1;
      dac_ldac_n <= 1'b1;
      wrap       <= 1'b0;
      done       <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state     <= PREFETCH;
            busy      <= 1'b1;
            len_q     <= cfg_len;
            div_q     <= (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
            oneshot_q <= cfg_oneshot;
            idx       <= '0;
            stop_pend <= 1'b0;
          end
        end

        PREFETCH: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            // Buffer read of idx lands directly in the output register.
            state      <= SETUP;
            to_daq     <= buffer[idx];
            sample_idx <= idx;
            idx        <= (idx < len_q) ? idx + IDX_ONE : '0;
          end
        end

        SETUP: begin
          state    <= STROBE;
          dac_we_n <= 1'b0;
          if (stop) stop_pend <= 1'b1;
        end

        STROBE: begin
          state      <= LATCH;
          dac_ldac_n <= 1'b0;
          wrap       <= (sample_idx == len_q);
          if (stop) stop_pend <= 1'b1;
        end

        LATCH: begin
          if (stop || stop_pend) begin
            state     <= IDLE;
            busy      <= 1'b0;
            stop_pend <= 1'b0;
          end else begin
            // SETUP+STROBE+LATCH take 3 clocks; WAIT pads to div+1 and so
            // lasts div-2 cycles, counted down to zero.
            state    <= WAIT;
            wait_cnt <= div_q - DIV_MIN;
          end
        end

        WAIT: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 16'd1;
          end else if (oneshot_q && (sample_idx == len_q)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= SETUP;
            to_daq     <= buffer[idx];
            sample_idx <= idx;
            idx        <= (idx < len_q) ? idx + IDX_ONE : '0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_wave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dac_wave_ctrl
//
// Self-checking bench for dac_wave_ctrl. Expected latched samples are pushed
// to a scoreboard queue when playback is started and popped by a monitor each
// time the DUT pulses dac_ldac_n.
// -----------------------------------------------------------------------------
module tb_dac_wave_ctrl;

  typedef struct {
    logic [9:0]  idx;
    logic [15:0] data;
    logic        wrap;
    int          period;  // clocks since previous latch, 0 = not checked
  } exp_t;

  logic        new_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        cfg_we  = 1'b0;
  logic [9:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic [9:0]  cfg_len  = '0;
  logic [15:0] cfg_div  = '0;
  logic        cfg_oneshot = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;

  logic [15:0] to_daq;
  logic        dac_we_n;
  logic        dac_ldac_n;
  logic        dac_rst_n;
  logic        busy;
  logic [9:0]  sample_idx;
  logic        wrap;
  logic        done;

  dac_wave_ctrl dut (
    .new_clk     (new_clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_len     (cfg_len),
    .cfg_div     (cfg_div),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .stop        (stop),
    .to_daq      (to_daq),
    .dac_we_n    (dac_we_n),
    .dac_ldac_n  (dac_ldac_n),
    .dac_rst_n   (dac_rst_n),
    .busy        (busy),
    .sample_idx  (sample_idx),
    .wrap        (wrap),
    .done        (done)
  );

  always #5 new_clk = ~new_clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_latch_cyc = 0;
  int   we_cnt = 0;
  int   ldac_cnt = 0;
  int   n_pushed = 0;
  int   stray_wrap = 0;
  logic prev_we_n = 1'b1;

  logic [15:0] tb_mem [1024];
  exp_t        sb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge new_clk) cyc <= cyc + 1;

  // Monitor: strobes and scoreboard comparison, sampled on the falling edge.
  always @(negedge new_clk) begin
    exp_t e;
    if (dac_we_n === 1'b0) we_cnt++;
    if (dac_ldac_n === 1'b1 && wrap === 1'b1) stray_wrap++;
    if (dac_ldac_n === 1'b0) begin
      ldac_cnt++;
      check("we_before_ldac", {31'd0, prev_we_n}, 32'd0);
      check("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("lat_idx", {22'd0, sample_idx}, {22'd0, e.idx});
        check("lat_data", {16'd0, to_daq}, {16'd0, e.data});
        check("lat_wrap", {31'd0, wrap}, {31'd0, e.wrap});
        if (e.period != 0) check("lat_period", cyc - last_latch_cyc, e.period);
      end
      last_latch_cyc = cyc;
    end
    prev_we_n = dac_we_n;
  end

  task automatic step();
    @(posedge new_clk);
    #1;
  endtask

  task automatic write_buf(input int addr, input logic [15:0] data);
    cfg_we   = 1'b1;
    cfg_addr = 10'(addr);
    cfg_data = data;
    step();
    cfg_we = 1'b0;
    tb_mem[addr] = data;
  endtask

  // Expected latches for samples first..first+count-1 of a run.
  task automatic push_run(input int len, input int div, input int count, input int first);
    exp_t e;
    int   i;
    for (int k = 0; k < count; k++) begin
      i        = (first + k) % (len + 1);
      e.idx    = 10'(i);
      e.data   = tb_mem[i];
      e.wrap   = (i == len);
      e.period = (first == 0 && k == 0) ? 0 : ((div < 3) ? 3 : div) + 1;
      sb_q.push_back(e);
      n_pushed++;
    end
  endtask

  task automatic pulse_start(input int len, input int div, input logic oneshot);
    cfg_len     = 10'(len);
    cfg_div     = 16'(div);
    cfg_oneshot = oneshot;
    start       = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_size(input string tag, input int n);
    int b = 0;
    while (sb_q.size() > n && b < 500) begin
      step();
      b++;
    end
    check({tag, "_drain"}, sb_q.size(), n);
  endtask

  // Called right after the last expected latch: the DUT is in WAIT.
  task automatic stop_in_wait(input string tag);
    int w;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check({tag, "_stop_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_stop_done"}, {31'd0, done}, 32'd0);
    w = we_cnt;
    repeat (12) step();
    check({tag, "_no_strobes"}, we_cnt, w);
  endtask

  task automatic wait_done(input string tag, input logic [15:0] last_data);
    int b = 0;
    while (done !== 1'b1 && b < 500) begin
      step();
      b++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_done_gap"}, cyc - last_latch_cyc, 2);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold"}, {16'd0, to_daq}, {16'd0, last_data});
    check({tag, "_sb_empty"}, sb_q.size(), 0);
    step();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold2"}, {16'd0, to_daq}, {16'd0, last_data});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_to_daq"}, {16'd0, to_daq}, 32'h8000);
    check({tag, "_we_n"}, {31'd0, dac_we_n}, 32'd1);
    check({tag, "_ldac_n"}, {31'd0, dac_ldac_n}, 32'd1);
    check({tag, "_rst_n"}, {31'd0, dac_rst_n}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idx"}, {22'd0, sample_idx}, 32'd0);
    check({tag, "_wrap"}, {31'd0, wrap}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and the extra dac_rst_n cycle.
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();
    check("rst_extra_cycle", {31'd0, dac_rst_n}, 32'd0);
    step();
    check("rst_release", {31'd0, dac_rst_n}, 32'd1);

    write_buf(0, 16'h1111);
    write_buf(1, 16'h2222);
    write_buf(2, 16'h3333);
    write_buf(3, 16'h4444);

    // Loop playback, stopped in WAIT after ten samples.
    push_run(3, 7, 10, 0);
    pulse_start(3, 7, 1'b0);
    check("loop_busy", {31'd0, busy}, 32'd1);
    wait_size("loop", 0);
    stop_in_wait("loop");

    // Stop during STROBE: LATCH still happens, then IDLE.
    push_run(3, 7, 1, 0);
    pulse_start(3, 7, 1'b0);
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("strobe_stop_latch", {31'd0, dac_ldac_n}, 32'd0);
    step();
    check("strobe_stop_busy", {31'd0, busy}, 32'd0);
    check("strobe_stop_done", {31'd0, done}, 32'd0);
    check("strobe_stop_sb", sb_q.size(), 0);

    // One-shot at minimum period (div 1 clamps to 3).
    push_run(2, 1, 3, 0);
    pulse_start(2, 1, 1'b1);
    wait_done("oneshot", tb_mem[2]);

    // start and stop together while idle.
    cfg_len = 10'd3;
    cfg_div = 16'd7;
    start   = 1'b1;
    stop    = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("collide_busy0", {31'd0, busy}, 32'd0);
    step();
    check("collide_busy1", {31'd0, busy}, 32'd0);

    // start while busy is ignored.
    push_run(1, 4, 4, 0);
    pulse_start(1, 4, 1'b0);
    wait_size("busy_start_a", 2);
    pulse_start(3, 3, 1'b1);
    wait_size("busy_start", 0);
    stop_in_wait("busy_start");

    // Live rewrite of sample 1 while sample 0 plays.
    push_run(3, 7, 1, 0);
    pulse_start(3, 7, 1'b0);
    wait_size("rewrite_a", 0);
    write_buf(1, 16'hABCD);
    push_run(3, 7, 3, 1);
    wait_size("rewrite", 0);
    stop_in_wait("rewrite");

    // Reset during WAIT, then replay the preserved buffer.
    push_run(3, 7, 1, 0);
    pulse_start(3, 7, 1'b0);
    wait_size("midrst_a", 0);
    reset = 1'b1;
    step();
    check_reset_outputs("midrst");
    step();
    reset = 1'b0;
    step();
    check("midrst_extra_rst_n", {31'd0, dac_rst_n}, 32'd0);
    check("midrst_extra_daq", {16'd0, to_daq}, 32'h8000);
    step();
    check("midrst_release", {31'd0, dac_rst_n}, 32'd1);
    push_run(3, 3, 4, 0);
    pulse_start(3, 3, 1'b1);
    wait_done("replay", tb_mem[3]);

    // cfg_len = 0: sample 0 every period with wrap every period.
    push_run(0, 5, 4, 0);
    pulse_start(0, 5, 1'b0);
    wait_size("len0", 0);
    stop_in_wait("len0");

    check("strobe_pairs", we_cnt, ldac_cnt);
    check("latch_total", ldac_cnt, n_pushed);
    check("stray_wrap", stray_wrap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
